// File: rtl/snn_pkg.sv
// Shared constants and loader state encoding for the SNN image-input path.
package snn_pkg;

    localparam int          MNIST_BYTES = 98;
    localparam int          PIX_ADDR_W  = 10;
    localparam logic [11:0] BAUD_CLKS   = 12'hA2D;

    typedef enum logic [1:0] {IDLE, UNPACK, WAIT_CORE} ldr_state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Serialises one received byte into 8 LSB-first single-bit writes, one per clock.
module snn_byte_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] din,
    output logic       we,
    output logic       wdata,
    output logic [2:0] bit_idx
);

    logic [6:0] shreg;

    // Bit 0 is presented on the load edge so the byte occupies exactly 8 write cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            we      <= 1'b0;
            wdata   <= 1'b0;
            bit_idx <= '0;
        end else if (load) begin
            shreg   <= din[7:1];
            we      <= 1'b1;
            wdata   <= din[0];
            bit_idx <= '0;
        end else if (we) begin
            if (bit_idx == 3'd7) begin
                we <= 1'b0;
            end else begin
                wdata   <= shreg[0];
                shreg   <= {1'b0, shreg[6:1]};
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

endmodule

// File: rtl/snn_img_loader.sv
// Collects MNIST_BYTES UART bytes into the 1-bit pixel RAM and hands the image to the core.
// Optional inter-byte timeout abort enabled by defining SNN_LOADER_RX_TIMEOUT_EN.
module snn_img_loader #(
    parameter int MNIST_BYTES  = snn_pkg::MNIST_BYTES,
    parameter int ADDR_W       = snn_pkg::PIX_ADDR_W,
    parameter int TIMEOUT_CLKS = 40 * int'(snn_pkg::BAUD_CLKS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              img_vld,
    input  logic              core_done,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic              frame_err
);

    import snn_pkg::*;

    localparam int CNT_W = $clog2(MNIST_BYTES + 1);

    if ((1 << ADDR_W) < MNIST_BYTES * 8) begin : g_addr_too_small
        $error("ADDR_W too small for MNIST_BYTES*8 pixels");
    end
    if (TIMEOUT_CLKS < 2) begin : g_timeout_too_small
        $error("TIMEOUT_CLKS must be at least 2");
    end

    ldr_state_t       state;
    logic [CNT_W-1:0] byte_cnt;
    logic [2:0]       bit_idx;
    logic             load;
    logic             last;

    assign load = (state == IDLE) && rx_rdy;
    assign last = ram_we && (bit_idx == 3'd7);

    snn_byte_unpacker u_unpack (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .din     (rx_data),
        .we      (ram_we),
        .wdata   (ram_wdata),
        .bit_idx (bit_idx)
    );

`ifdef SNN_LOADER_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    logic [TO_W-1:0] to_cnt;
`else
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            byte_cnt <= '0;
            ram_addr <= '0;
            img_vld  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
`ifdef SNN_LOADER_RX_TIMEOUT_EN
            to_cnt    <= '0;
            frame_err <= 1'b0;
`endif
        end else begin
            // A dropped byte outranks a simultaneous clear.
            if (rx_rdy && state != IDLE)
                overrun <= 1'b1;
            else if (clr_ovr)
                overrun <= 1'b0;
`ifdef SNN_LOADER_RX_TIMEOUT_EN
            frame_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (rx_rdy) begin
                        state    <= UNPACK;
                        busy     <= 1'b1;
                        ram_addr <= ADDR_W'(byte_cnt) << 3;
                    end
`ifdef SNN_LOADER_RX_TIMEOUT_EN
                    if (rx_rdy || byte_cnt == '0) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
                        to_cnt    <= '0;
                        byte_cnt  <= '0;
                        frame_err <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                UNPACK: begin
                    if (last) begin
                        if (byte_cnt == CNT_W'(MNIST_BYTES - 1)) begin
                            byte_cnt <= '0;
                            img_vld  <= 1'b1;
                            state    <= WAIT_CORE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        ram_addr <= ram_addr + 1'b1;
                    end
                end
                WAIT_CORE: begin
                    if (core_done) begin
                        img_vld <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// Directed bench for snn_img_loader: pixel unpacking, image handshake, overrun, reset and timeout.
module tb_snn_img_loader;

    localparam int NB = 98;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_rdy = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_wdata;
    logic          img_vld;
    logic          core_done = 1'b0;
    logic          busy;
    logic          overrun;
    logic          clr_ovr = 1'b0;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    logic          mem [0:(1<<AW)-1];
    int            we_cnt, busy_cnt, fe_cnt, wn, max_addr;
    logic [AW-1:0] wa [0:15];
    logic          wd [0:15];

    snn_img_loader #(.MNIST_BYTES(NB), .ADDR_W(AW), .TIMEOUT_CLKS(100)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .img_vld   (img_vld),
        .core_done (core_done),
        .busy      (busy),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pixel RAM model and activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (ram_we) begin
            mem[ram_addr] = ram_wdata;
            we_cnt++;
            if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
            if (wn < 16) begin
                wa[wn] = ram_addr;
                wd[wn] = ram_wdata;
                wn++;
            end
        end
        if (busy) busy_cnt++;
        if (frame_err) fe_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_rdy  = 1'b1;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_img();
        for (int k = 0; k < NB; k++) begin
            send(8'(k));
            idle(8);
        end
    endtask

    task automatic check_byte(input string tag, input int base, input logic [7:0] val);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < 8; i++) got[i] = wd[i];
        chk({tag, "_nwr"}, wn, 8);
        chk({tag, "_a0"}, int'(wa[0]), base);
        chk({tag, "_a7"}, int'(wa[7]), base + 7);
        chk({tag, "_data"}, int'(got), int'(val));
    endtask

    initial begin
        int lat, bad;
        we_cnt = 0; busy_cnt = 0; fe_cnt = 0; wn = 0; max_addr = -1;

        // Reset values while held in reset
        #1;
        chk("rst_we", int'(ram_we), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_wdata", int'(ram_wdata), 0);
        chk("rst_vld", int'(img_vld), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_ferr", int'(frame_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full image, byte k = k
        for (int k = 0; k < NB - 1; k++) begin
            send(8'(k));
            idle(8);
        end
        send(8'(NB - 1));
        lat = 0;
        while (!img_vld && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        // img_vld registered at edge N+lat, so the core first samples it at N+lat+1
        chk("t1_vld_lat", lat + 1, 9);
        bad = 0;
        for (int p = 0; p < NB * 8; p++)
            if (mem[p] !== 1'(((p / 8) >> (p % 8)) & 1)) bad++;
        chk("t1_pix_bad", bad, 0);
        chk("t1_we_cnt", we_cnt, NB * 8);
        chk("t1_max_addr", max_addr, NB * 8 - 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("t1_vld_drop", int'(img_vld), 0);

        // 2: single byte 0xA5
        wn = 0; busy_cnt = 0;
        send(8'hA5);
        idle(10);
        check_byte("t2", 0, 8'hA5);
        chk("t2_busy", busy_cnt, 8);
        chk("t2_vld", int'(img_vld), 0);

        // 3: byte dropped in WAIT_CORE, release, next byte at pixel 0, clear overrun
        do_reset();
        send_img();
        we_cnt = 0;
        send(8'hFF);
        idle(9);
        chk("t3_drop_we", we_cnt, 0);
        chk("t3_ovr", int'(overrun), 1);
        chk("t3_vld_hold", int'(img_vld), 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        chk("t3_vld_drop", int'(img_vld), 0);
        chk("t3_busy", int'(busy), 0);
        wn = 0;
        send(8'h01);
        idle(8);
        check_byte("t3", 0, 8'h01);
        clr_ovr = 1'b1;
        @(negedge clk);
        clr_ovr = 1'b0;
        chk("t3_ovr_clr", int'(overrun), 0);

        // 6: rx_rdy and clr_ovr together in WAIT_CORE
        do_reset();
        send_img();
        rx_data = 8'h55; rx_rdy = 1'b1; clr_ovr = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0; clr_ovr = 1'b0;
        chk("t6_ovr_set_wins", int'(overrun), 1);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;

        // 4: asynchronous reset mid-image
        do_reset();
        for (int k = 0; k < 40; k++) begin
            send(8'hC3);
            idle(8);
        end
        send(8'h3C);
        idle(3);
        rst_n = 1'b0;
        #1;
        chk("t4_we", int'(ram_we), 0);
        chk("t4_addr", int'(ram_addr), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_ovr", int'(overrun), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wn = 0;
        send(8'hE7);
        idle(8);
        check_byte("t4", 0, 8'hE7);

        // 5: 3 bytes, then a long idle gap
        do_reset();
        fe_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send(8'h81);
            idle(8);
        end
        idle(110);
        wn = 0;
        send(8'h24);
        idle(8);
`ifdef SNN_LOADER_RX_TIMEOUT_EN
        chk("t5_ferr_pulses", fe_cnt, 1);
        check_byte("t5", 0, 8'h24);
`else
        chk("t5_ferr_pulses", fe_cnt, 0);
        check_byte("t5", 24, 8'h24);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
